// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared raster constants and pixel type for the line buffer
package video_pkg;

    localparam int P_width = 6;
    localparam int P_line  = 256;
    localparam int P_lines = 240;

    typedef logic [P_width-1:0] pixel_t;

    localparam pixel_t P_black = 6'h0F;

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - 2 x 256 x P_width simple dual-port RAM with registered read
module line_ram
    import video_pkg::*;
(
    input  logic       clk_i,
    input  logic       wr_en_i,
    input  logic       wr_bank_i,
    input  logic [7:0] wr_addr_i,
    input  pixel_t     wr_data_i,
    input  logic       rd_bank_i,
    input  logic [7:0] rd_addr_i,
    output pixel_t     rd_data_o
);

    pixel_t mem [2*P_line];
    pixel_t rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[{wr_bank_i, wr_addr_i}] <= wr_data_i;
        end
        rd_data_q <= mem[{rd_bank_i, rd_addr_i}];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/video_line_buffer.sv
// rtl/video_line_buffer.sv - ping-pong scanline buffer with sync/blank realignment
module video_line_buffer
    import video_pkg::*;
(
    input  logic        I_clock,
    input  logic        I_reset,
    input  pixel_t      I_wr_pixel,
    input  logic        I_wr_valid,
    input  logic        I_wr_line_end,
    output logic        O_wr_ready,
    input  logic        I_rise,
    input  logic [15:0] I_hcount,
    input  logic [15:0] I_vcount,
    input  logic        I_not_blank,
    input  logic        I_hsync,
    input  logic        I_vsync,
    output pixel_t      O_pixel,
    output logic        O_not_blank,
    output logic        O_hsync,
    output logic        O_vsync,
    output logic        O_overrun,
    output logic        O_underrun
);

    logic [1:0]      full_q, full_d;
    logic [1:0][8:0] len_q, len_d;
    logic            wr_bank_q, wr_bank_d;
    logic [8:0]      wr_ptr_q, wr_ptr_d;
    logic            rd_bank_q, rd_bank_d;
    logic            disp_bank_q, disp_bank_d;
    logic            disp_valid_q, disp_valid_d;

    logic            show_q;
    pixel_t          pixel_q;
    logic [1:0]      nb_q, hs_q, vs_q;
    logic            overrun_q, underrun_q;

    logic            wr_ready, accept, close, ls, show;
    logic [8:0]      ptr_inc;
    logic [7:0]      rd_addr;
    pixel_t          rd_data;

    assign wr_ready = !full_q[wr_bank_q];
    assign accept   = I_wr_valid & wr_ready;
    assign ptr_inc  = wr_ptr_q + 9'(accept);
    assign close    = wr_ready & (I_wr_line_end | (accept & (ptr_inc == 9'(P_line))));
    assign ls       = I_rise & (I_hcount == 16'd0) & (I_vcount < 16'(P_lines));

    // hcount 1..256 maps to RAM addresses 0..255; hcount 0 wraps harmlessly to 255
    assign rd_addr  = I_hcount[7:0] - 8'd1;
    assign show     = I_not_blank & disp_valid_q & ({1'b0, rd_addr} < len_q[disp_bank_q]);

    always_comb begin
        full_d       = full_q;
        len_d        = len_q;
        wr_bank_d    = wr_bank_q;
        wr_ptr_d     = ptr_inc;
        rd_bank_d    = rd_bank_q;
        disp_bank_d  = disp_bank_q;
        disp_valid_d = disp_valid_q;

        if (close) begin
            len_d[wr_bank_q]  = ptr_inc;
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_ptr_d          = '0;
        end

        // Reader decides on pre-update full_q, so a line closed this cycle waits one line
        if (ls) begin
            if (disp_valid_q) begin
                full_d[disp_bank_q] = 1'b0;
            end
            if (full_q[rd_bank_q]) begin
                disp_bank_d  = rd_bank_q;
                rd_bank_d    = ~rd_bank_q;
                disp_valid_d = 1'b1;
            end else begin
                disp_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            full_q       <= '0;
            len_q        <= '0;
            wr_bank_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_bank_q    <= 1'b0;
            disp_bank_q  <= 1'b0;
            disp_valid_q <= 1'b0;
            show_q       <= 1'b0;
            pixel_q      <= P_black;
            nb_q         <= '0;
            hs_q         <= '0;
            vs_q         <= '0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            full_q       <= full_d;
            len_q        <= len_d;
            wr_bank_q    <= wr_bank_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_bank_q    <= rd_bank_d;
            disp_bank_q  <= disp_bank_d;
            disp_valid_q <= disp_valid_d;
            show_q       <= show;
            pixel_q      <= show_q ? rd_data : P_black;
            nb_q         <= {nb_q[0], I_not_blank};
            hs_q         <= {hs_q[0], I_hsync};
            vs_q         <= {vs_q[0], I_vsync};
            overrun_q    <= I_wr_valid & !wr_ready;
            underrun_q   <= ls & !full_q[rd_bank_q];
        end
    end

    line_ram u_line_ram (
        .clk_i     (I_clock),
        .wr_en_i   (accept),
        .wr_bank_i (wr_bank_q),
        .wr_addr_i (wr_ptr_q[7:0]),
        .wr_data_i (I_wr_pixel),
        .rd_bank_i (disp_bank_q),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign O_wr_ready  = wr_ready;
    assign O_pixel     = pixel_q;
    assign O_not_blank = nb_q[1];
    assign O_hsync     = hs_q[1];
    assign O_vsync     = vs_q[1];
    assign O_overrun   = overrun_q;
    assign O_underrun  = underrun_q;

endmodule

// File: tb/tb_video_line_buffer.sv
// tb/tb_video_line_buffer.sv - scoreboard bench for video_line_buffer
module tb_video_line_buffer;
    import video_pkg::*;

    logic        clk = 1'b0;
    logic        I_reset = 1'b1;
    pixel_t      I_wr_pixel = '0;
    logic        I_wr_valid = 1'b0, I_wr_line_end = 1'b0, I_rise = 1'b1;
    logic [15:0] I_hcount = 16'd300, I_vcount = 16'd0;
    logic        I_not_blank = 1'b0, I_hsync = 1'b0, I_vsync = 1'b0;
    pixel_t      O_pixel;
    logic        O_wr_ready, O_not_blank, O_hsync, O_vsync, O_overrun, O_underrun;

    always #5 clk = ~clk;

    video_line_buffer dut (
        .I_clock(clk), .I_reset(I_reset), .I_wr_pixel(I_wr_pixel), .I_wr_valid(I_wr_valid),
        .I_wr_line_end(I_wr_line_end), .O_wr_ready(O_wr_ready), .I_rise(I_rise),
        .I_hcount(I_hcount), .I_vcount(I_vcount), .I_not_blank(I_not_blank),
        .I_hsync(I_hsync), .I_vsync(I_vsync), .O_pixel(O_pixel), .O_not_blank(O_not_blank),
        .O_hsync(O_hsync), .O_vsync(O_vsync), .O_overrun(O_overrun), .O_underrun(O_underrun)
    );

    typedef struct packed {
        logic [5:0] pix;
        logic       nb;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0;
    int          under_cnt = 0, over_cnt = 0;
    logic [5:0]  disp_line [256];
    int          disp_len = 0;
    bit          disp_ok = 1'b0;

    // driven values, applied one step later just after the rising edge
    logic        d_reset = 1'b1, d_valid = 1'b0, d_le = 1'b0, d_nb = 1'b0, d_hs = 1'b0, d_vs = 1'b0;
    logic [5:0]  d_pix = '0;
    logic [15:0] d_h = 16'd300, d_v = 16'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] gen(input int tag, input int i);
        return 6'((tag * 7 + i) & 63);
    endfunction

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        I_reset = d_reset; I_wr_valid = d_valid; I_wr_pixel = d_pix; I_wr_line_end = d_le;
        I_hcount = d_h; I_vcount = d_v; I_not_blank = d_nb; I_hsync = d_hs; I_vsync = d_vs;
        e.nb  = d_nb;
        e.hs  = d_hs;
        e.vs  = d_vs;
        e.pix = (d_nb && disp_ok && (int'(d_h) - 1) < disp_len) ? disp_line[d_h - 16'd1] : P_black;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        d_h = 16'd300; d_nb = 1'b0; d_hs = 1'b0; d_vs = 1'b0; d_valid = 1'b0; d_le = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_px(input int tag, input int n, input bit close_line);
        for (int i = 0; i < n; i++) begin
            d_valid = 1'b1;
            d_pix   = gen(tag, i);
            step();
        end
        d_valid = 1'b0;
        if (close_line) begin
            d_le = 1'b1;
            step();
            d_le = 1'b0;
        end
    endtask

    task automatic run_line(input int v, input bit ok, input int tag, input int len,
                            input bit le_at_ls, input int hend);
        disp_ok  = ok;
        disp_len = len;
        for (int i = 0; i < 256; i++) disp_line[i] = gen(tag, i);
        for (int h = 0; h < hend; h++) begin
            d_h  = 16'(h);
            d_v  = 16'(v);
            d_nb = (h >= 1) && (h <= 256) && (v < 240);
            d_hs = (h >= 270) && (h < 280);
            d_vs = (v % 3 == 0) && (h >= 280);
            d_le = (h == 0) && le_at_ls;
            step();
        end
        idle(3);
    endtask

    task automatic do_reset();
        d_reset = 1'b1;
        idle(3);
        sb.delete();
        d_reset = 1'b0;
        step();
    endtask

    always @(negedge clk) begin
        if (!I_reset) begin
            if (O_underrun) under_cnt++;
            if (O_overrun)  over_cnt++;
            if (sb.size() >= 3) begin
                exp_t e;
                e = sb.pop_front();
                check_eq("pixel", 32'(O_pixel), 32'(e.pix));
                check_eq("not_blank", 32'(O_not_blank), 32'(e.nb));
                check_eq("hsync", 32'(O_hsync), 32'(e.hs));
                check_eq("vsync", 32'(O_vsync), 32'(e.vs));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        do_reset();
        check_eq("reset_wr_ready", 32'(O_wr_ready), 32'd1);
        check_eq("reset_pixel", 32'(O_pixel), 32'(P_black));
        check_eq("reset_underrun", 32'(O_underrun), 32'd0);
        check_eq("reset_overrun", 32'(O_overrun), 32'd0);
        check_eq("reset_syncs", 32'({O_not_blank, O_hsync, O_vsync}), 32'd0);

        // full line then display
        write_px(0, 256, 1'b0);
        base = under_cnt;
        run_line(0, 1'b1, 0, 256, 1'b0, 300);
        check_eq("full_line_underrun", 32'(under_cnt - base), 32'd0);

        // no data: single underrun, black line
        base = under_cnt;
        run_line(1, 1'b0, 0, 0, 1'b0, 300);
        check_eq("empty_line_underrun", 32'(under_cnt - base), 32'd1);

        // two lines fill both banks, third is refused
        write_px(1, 256, 1'b0);
        write_px(2, 256, 1'b0);
        idle(2);
        check_eq("both_full_ready", 32'(O_wr_ready), 32'd0);
        base = over_cnt;
        write_px(9, 3, 1'b0);
        idle(2);
        check_eq("overrun_pulses", 32'(over_cnt - base), 32'd3);
        base = under_cnt;
        run_line(2, 1'b1, 1, 256, 1'b0, 300);
        check_eq("shown_bank_held", 32'(O_wr_ready), 32'd0);
        run_line(3, 1'b1, 2, 256, 1'b0, 300);
        check_eq("released_ready", 32'(O_wr_ready), 32'd1);
        write_px(3, 256, 1'b0);
        run_line(4, 1'b1, 3, 256, 1'b0, 300);
        check_eq("order_underrun", 32'(under_cnt - base), 32'd0);

        // short line
        write_px(4, 100, 1'b1);
        run_line(5, 1'b1, 4, 100, 1'b0, 300);

        // close coincident with line start
        write_px(5, 50, 1'b0);
        base = under_cnt;
        run_line(6, 1'b0, 0, 0, 1'b1, 300);
        check_eq("coincident_underrun", 32'(under_cnt - base), 32'd1);
        base = under_cnt;
        run_line(7, 1'b1, 5, 50, 1'b0, 300);
        check_eq("deferred_line_underrun", 32'(under_cnt - base), 32'd0);

        // reset mid-line with both banks full
        write_px(6, 256, 1'b0);
        idle(2);
        check_eq("pre_reset_ready", 32'(O_wr_ready), 32'd0);
        run_line(250, 1'b0, 0, 0, 1'b0, 100);
        do_reset();
        check_eq("post_reset_ready", 32'(O_wr_ready), 32'd1);
        check_eq("post_reset_pixel", 32'(O_pixel), 32'(P_black));
        base = under_cnt;
        run_line(0, 1'b0, 0, 0, 1'b0, 300);
        check_eq("post_reset_underrun", 32'(under_cnt - base), 32'd1);

        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
